// File: rtl/ccp_evict_scheduler_if.sv
// Handshake bundle between the CCP tag pipe, data-array read port, WB channel and the eviction scheduler.
// The wb_cmd_clean signal exists only when CCP_EVICT_CLEAN_NOTIFY_EN is defined.
interface ccp_evict_scheduler_if #(
  parameter int N_SETS              = 1024,
  parameter int ADDRESS_W           = 40,
  parameter int CACHE_LINE_OFFSET_W = 6,
  parameter int N_WAYS              = 16,
  parameter int EVQ_DEPTH           = 4,
  parameter int BEATS_PER_LINE      = 2
);
  localparam int SET_PER_BANK_W = $clog2(N_SETS / 2);
  localparam int TAG_W  = ADDRESS_W - (1 + CACHE_LINE_OFFSET_W + SET_PER_BANK_W);
  localparam int WAY_W  = $clog2(N_WAYS);
  localparam int BEAT_W = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1;
  localparam int CNT_W  = $clog2(EVQ_DEPTH) + 1;

  logic                      ev_valid;
  logic                      ev_ready;
  logic [ADDRESS_W-1:0]      ev_op_addr;
  logic [TAG_W-1:0]          ev_tag;
  logic [WAY_W-1:0]          ev_way;
  logic                      ev_dirty;
  logic                      wb_cmd_valid;
  logic                      wb_cmd_ready;
  logic [ADDRESS_W-1:0]      wb_cmd_addr;
`ifdef CCP_EVICT_CLEAN_NOTIFY_EN
  logic                      wb_cmd_clean;
`endif
  logic                      dat_rd_valid;
  logic                      dat_rd_ready;
  logic [SET_PER_BANK_W:0]   dat_rd_set;
  logic [WAY_W-1:0]          dat_rd_way;
  logic [BEAT_W-1:0]         dat_rd_beat;
  logic [CNT_W-1:0]          evq_count;
  logic                      busy;

  // The scheduler is the slave of the tag pipe and drives the WB / data-array requests.
  modport slave (
    input  ev_valid, ev_op_addr, ev_tag, ev_way, ev_dirty, wb_cmd_ready, dat_rd_ready,
    output ev_ready, wb_cmd_valid, wb_cmd_addr,
`ifdef CCP_EVICT_CLEAN_NOTIFY_EN
    output wb_cmd_clean,
`endif
    output dat_rd_valid, dat_rd_set, dat_rd_way, dat_rd_beat, evq_count, busy
  );

  modport master (
    output ev_valid, ev_op_addr, ev_tag, ev_way, ev_dirty, wb_cmd_ready, dat_rd_ready,
    input  ev_ready, wb_cmd_valid, wb_cmd_addr,
`ifdef CCP_EVICT_CLEAN_NOTIFY_EN
    input  wb_cmd_clean,
`endif
    input  dat_rd_valid, dat_rd_set, dat_rd_way, dat_rd_beat, evq_count, busy
  );
endinterface

// File: rtl/ccp_evict_scheduler.sv
// Victim eviction queue and writeback sequencer: one WB command then BEATS_PER_LINE data reads per dirty line.
// Define CCP_EVICT_CLEAN_NOTIFY_EN to also send clean victims as WB commands flagged wb_cmd_clean.
module ccp_evict_scheduler #(
  parameter int N_SETS              = 1024,
  parameter int ADDRESS_W           = 40,
  parameter int CACHE_LINE_OFFSET_W = 6,
  parameter int N_WAYS              = 16,
  parameter int EVQ_DEPTH           = 4,
  parameter int BEATS_PER_LINE      = 2
) (
  input logic             clk,
  input logic             reset_n,
  ccp_evict_scheduler_if.slave bus
);
  localparam int OFF            = CACHE_LINE_OFFSET_W;
  localparam int SET_PER_BANK_W = $clog2(N_SETS / 2);
  localparam int SET_END        = SET_PER_BANK_W + OFF;
  localparam int TAG_W          = ADDRESS_W - (1 + OFF + SET_PER_BANK_W);
  localparam int WAY_W          = $clog2(N_WAYS);
  localparam int BEAT_W         = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1;
  localparam int PTR_W          = $clog2(EVQ_DEPTH);
  localparam int CNT_W          = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_e;

  state_e               state_q, state_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic [ADDRESS_W-1:0] addr_q [EVQ_DEPTH];
  logic [WAY_W-1:0]     way_q  [EVQ_DEPTH];
  logic [EVQ_DEPTH-1:0] dirty_q;

  logic                 push, pop, head_dirty;
  logic [ADDRESS_W-1:0] ev_addr, head_addr;

  // The tag's LSB sits in the bank-select hole of the op address; the bank bit itself comes from the op.
  assign ev_addr = {bus.ev_tag[TAG_W-1:1], bus.ev_op_addr[SET_END+1], bus.ev_tag[0],
                    bus.ev_op_addr[SET_END-1:OFF], {OFF{1'b0}}};

  assign bus.ev_ready = (count_q != CNT_W'(EVQ_DEPTH));
  assign push         = bus.ev_valid && bus.ev_ready;
  assign head_addr    = addr_q[rd_ptr_q];
  assign head_dirty   = dirty_q[rd_ptr_q];

  assign bus.wb_cmd_addr = head_addr;
  assign bus.dat_rd_set  = {head_addr[SET_END+1], head_addr[SET_END-1:OFF]};
  assign bus.dat_rd_way  = way_q[rd_ptr_q];
  assign bus.dat_rd_beat = beat_q;
  assign bus.evq_count   = count_q;
  assign bus.busy        = (count_q != '0) || (state_q != IDLE);
`ifdef CCP_EVICT_CLEAN_NOTIFY_EN
  assign bus.wb_cmd_clean = !head_dirty;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < EVQ_DEPTH; i++) begin
        addr_q[i] <= '0;
        way_q[i]  <= '0;
      end
      dirty_q <= '0;
    end else if (push) begin
      addr_q[wr_ptr_q]  <= ev_addr;
      way_q[wr_ptr_q]   <= bus.ev_way;
      dirty_q[wr_ptr_q] <= bus.ev_dirty;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // The head entry is only popped once its last request is accepted, so payloads stay stable.
  always_comb begin
    state_d          = state_q;
    beat_d           = beat_q;
    pop              = 1'b0;
    bus.wb_cmd_valid = 1'b0;
    bus.dat_rd_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
`ifdef CCP_EVICT_CLEAN_NOTIFY_EN
          state_d = CMD;
`else
          if (head_dirty) state_d = CMD;
          else            pop     = 1'b1;
`endif
        end
      end
      CMD: begin
        bus.wb_cmd_valid = 1'b1;
        if (bus.wb_cmd_ready) begin
`ifdef CCP_EVICT_CLEAN_NOTIFY_EN
          if (head_dirty) begin
            state_d = DATA;
            beat_d  = '0;
          end else begin
            pop     = 1'b1;
            state_d = IDLE;
          end
`else
          state_d = DATA;
          beat_d  = '0;
`endif
        end
      end
      DATA: begin
        bus.dat_rd_valid = 1'b1;
        if (bus.dat_rd_ready) begin
          if (beat_q == BEAT_W'(BEATS_PER_LINE - 1)) begin
            pop     = 1'b1;
            state_d = IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ccp_evict_scheduler.sv
// Directed bench for ccp_evict_scheduler with hand-computed expected addresses, sets and counts.
// Build with CCP_EVICT_CLEAN_NOTIFY_EN defined to exercise the clean-notify variant.
module tb_ccp_evict_scheduler;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int cmdCount = 0;
  int cmdBase = 0;

  ccp_evict_scheduler_if bus ();

  ccp_evict_scheduler dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset_n && bus.wb_cmd_valid && bus.wb_cmd_ready) cmdCount <= cmdCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic valid, input logic [39:0] opAddr, input logic [23:0] tag,
                               input logic [3:0] way, input logic dirty);
    bus.ev_valid   = valid;
    bus.ev_op_addr = opAddr;
    bus.ev_tag     = tag;
    bus.ev_way     = way;
    bus.ev_dirty   = dirty;
  endtask

  task automatic pushEntry(input string name, input logic [39:0] opAddr, input logic [23:0] tag,
                           input logic [3:0] way, input logic dirty);
    applyStimulus(1'b1, opAddr, tag, way, dirty);
    checkOutput({name, "_ev_ready"}, bus.ev_ready, 1);
    step();
    applyStimulus(1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic waitCmd(input string name);
    int n = 0;
    while (!bus.wb_cmd_valid && n < 20) begin
      step();
      n++;
    end
    checkOutput({name, "_cmd_wait"}, bus.wb_cmd_valid, 1);
  endtask

  task automatic doDirtyTransfer(input string name, input logic [39:0] expAddr, input logic [3:0] expWay,
                                 input logic [9:0] expSet, input int holdCycles, input int expCountAfter);
    waitCmd(name);
    checkOutput({name, "_cmd_addr"}, bus.wb_cmd_addr, expAddr);
`ifdef CCP_EVICT_CLEAN_NOTIFY_EN
    checkOutput({name, "_cmd_clean"}, bus.wb_cmd_clean, 0);
`endif
    bus.wb_cmd_ready = 1'b1;
    step();
    bus.wb_cmd_ready = 1'b0;
    checkOutput({name, "_cmd_done"}, bus.wb_cmd_valid, 0);
    for (int i = 0; i <= holdCycles; i++) begin
      if (i > 0) step();
      checkOutput({name, "_rd_valid0"}, bus.dat_rd_valid, 1);
      checkOutput({name, "_rd_beat0"}, bus.dat_rd_beat, 0);
      checkOutput({name, "_rd_set"}, bus.dat_rd_set, expSet);
      checkOutput({name, "_rd_way"}, bus.dat_rd_way, expWay);
    end
    bus.dat_rd_ready = 1'b1;
    step();
    checkOutput({name, "_rd_valid1"}, bus.dat_rd_valid, 1);
    checkOutput({name, "_rd_beat1"}, bus.dat_rd_beat, 1);
    step();
    bus.dat_rd_ready = 1'b0;
    checkOutput({name, "_rd_done"}, bus.dat_rd_valid, 0);
    checkOutput({name, "_count_after"}, bus.evq_count, expCountAfter);
  endtask

  initial begin
    applyStimulus(1'b0, '0, '0, '0, 1'b0);
    bus.wb_cmd_ready = 1'b0;
    bus.dat_rd_ready = 1'b0;

    // Reset values
    step();
    step();
    checkOutput("rst_ev_ready", bus.ev_ready, 1);
    checkOutput("rst_cmd_valid", bus.wb_cmd_valid, 0);
    checkOutput("rst_rd_valid", bus.dat_rd_valid, 0);
    checkOutput("rst_count", bus.evq_count, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_addr", bus.wb_cmd_addr, 0);
    checkOutput("rst_set", bus.dat_rd_set, 0);
    checkOutput("rst_way", bus.dat_rd_way, 0);
    checkOutput("rst_beat", bus.dat_rd_beat, 0);
    reset_n = 1'b1;
    step();

    // Single dirty eviction: minimum latency and command hold
    pushEntry("t1", 40'h00_0000_8040, 24'h000003, 4'd2, 1'b1);
    checkOutput("t1_count", bus.evq_count, 1);
    checkOutput("t1_idle_cycle", bus.wb_cmd_valid, 0);
    checkOutput("t1_busy", bus.busy, 1);
    step();
    checkOutput("t1_cmd_valid", bus.wb_cmd_valid, 1);
    checkOutput("t1_cmd_addr", bus.wb_cmd_addr, 40'h00_0002_8040);
    step();
    checkOutput("t1_cmd_hold", bus.wb_cmd_valid, 1);
    checkOutput("t1_addr_hold", bus.wb_cmd_addr, 40'h00_0002_8040);
    doDirtyTransfer("t1", 40'h00_0002_8040, 4'd2, 10'h001, 0, 0);
    checkOutput("t1_busy_end", bus.busy, 0);

    // Bank bit from op address, way 5, data-ready stall of 5 cycles
    pushEntry("t2", 40'h00_0001_8040, 24'h000003, 4'd5, 1'b1);
    doDirtyTransfer("t2", 40'h00_0003_8040, 4'd5, 10'h201, 5, 0);

    // Fill the queue behind a stalled command, then push against a full queue
    pushEntry("t3a", 40'h00_0000_0040, 24'h000002, 4'd7, 1'b1);
    pushEntry("t3b", 40'h00_0000_0080, 24'h000002, 4'd8, 1'b1);
    pushEntry("t3c", 40'h00_0000_00C0, 24'h000002, 4'd9, 1'b1);
    pushEntry("t3d", 40'h00_0000_0100, 24'h000002, 4'd10, 1'b1);
    checkOutput("t3_full_ready", bus.ev_ready, 0);
    checkOutput("t3_full_count", bus.evq_count, 4);
    applyStimulus(1'b1, 40'h00_0000_0140, 24'h000002, 4'd11, 1'b1);
    step();
    checkOutput("t3_refused_count", bus.evq_count, 4);
    doDirtyTransfer("t3a", 40'h00_0002_0040, 4'd7, 10'h001, 0, 3);
    checkOutput("t3_ready_after_pop", bus.ev_ready, 1);
    step();
    applyStimulus(1'b0, '0, '0, '0, 1'b0);
    checkOutput("t3_refill_count", bus.evq_count, 4);
    doDirtyTransfer("t3b", 40'h00_0002_0080, 4'd8, 10'h002, 0, 3);
    doDirtyTransfer("t3c", 40'h00_0002_00C0, 4'd9, 10'h003, 0, 2);
    doDirtyTransfer("t3d", 40'h00_0002_0100, 4'd10, 10'h004, 0, 1);
    doDirtyTransfer("t3e", 40'h00_0002_0140, 4'd11, 10'h005, 0, 0);

    // Clean victim between two dirty ones
    cmdBase = cmdCount;
    pushEntry("t4a", 40'h00_0000_0300, 24'h000004, 4'd0, 1'b1);
    pushEntry("t4b", 40'h00_0000_0340, 24'h000004, 4'd1, 1'b0);
    pushEntry("t4c", 40'h00_0000_0380, 24'h000004, 4'd2, 1'b1);
    checkOutput("t4_count", bus.evq_count, 3);
    doDirtyTransfer("t4a", 40'h00_0004_0300, 4'd0, 10'h00C, 0, 2);
`ifdef CCP_EVICT_CLEAN_NOTIFY_EN
    waitCmd("t4b");
    checkOutput("t4b_cmd_addr", bus.wb_cmd_addr, 40'h00_0004_0340);
    checkOutput("t4b_cmd_clean", bus.wb_cmd_clean, 1);
    bus.wb_cmd_ready = 1'b1;
    step();
    bus.wb_cmd_ready = 1'b0;
    checkOutput("t4b_no_data", bus.dat_rd_valid, 0);
    checkOutput("t4b_count", bus.evq_count, 1);
`endif
    doDirtyTransfer("t4c", 40'h00_0004_0380, 4'd2, 10'h00E, 0, 0);
`ifdef CCP_EVICT_CLEAN_NOTIFY_EN
    checkOutput("t4_cmd_total", cmdCount - cmdBase, 3);
`else
    checkOutput("t4_cmd_total", cmdCount - cmdBase, 2);
`endif

    // Reset while reading data with more entries queued
    pushEntry("t6a", 40'h00_0000_0200, 24'h000006, 4'd3, 1'b1);
    pushEntry("t6b", 40'h00_0000_0240, 24'h000006, 4'd4, 1'b1);
    pushEntry("t6c", 40'h00_0000_0280, 24'h000006, 4'd5, 1'b1);
    pushEntry("t6d", 40'h00_0000_02C0, 24'h000006, 4'd6, 1'b1);
    waitCmd("t6");
    bus.wb_cmd_ready = 1'b1;
    step();
    bus.wb_cmd_ready = 1'b0;
    checkOutput("t6_in_data", bus.dat_rd_valid, 1);
    checkOutput("t6_count_pre", bus.evq_count, 4);
    reset_n = 1'b0;
    #1;
    checkOutput("t6_cmd_valid", bus.wb_cmd_valid, 0);
    checkOutput("t6_rd_valid", bus.dat_rd_valid, 0);
    checkOutput("t6_count", bus.evq_count, 0);
    checkOutput("t6_busy", bus.busy, 0);
    checkOutput("t6_ev_ready", bus.ev_ready, 1);
    step();
    reset_n = 1'b1;
    step();
    step();
    step();
    checkOutput("t6_no_resume_cmd", bus.wb_cmd_valid, 0);
    checkOutput("t6_no_resume_rd", bus.dat_rd_valid, 0);
    checkOutput("t6_no_resume_busy", bus.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
